// File: rtl/stream_in_if.sv
// Word-stream input and block-output bundle for the 16-to-128 deserializer.
interface stream_in_if;
  logic         vin;
  logic         tin;
  logic [15:0]  din;
  logic         rdy;
  logic         vout;
  logic         tout;
  logic [127:0] dout;
  logic         err;
  logic         ovf;
  logic         busy;

  modport slave (
    input  vin, tin, din, rdy,
    output vout, tout, dout, err, ovf, busy
  );

  modport master (
    output vin, tin, din, rdy,
    input  vout, tout, dout, err, ovf, busy
  );
endinterface

// File: rtl/stream_in.sv
// Deserializes eight 16-bit typed words (LSW first) into one 128-bit block
// with a single-entry output register, type-mismatch and overflow pulses.
module stream_in (
  input  logic        clk,
  input  logic        rst,
  stream_in_if.slave  s
);

  logic [127:0] shreg_r, shreg_s;
  logic [2:0]   cnt_r, cnt_s;
  logic         type_r, type_s;
  logic         mismatch_s, complete_s, load_s, drop_s;
  logic [127:0] shifted_s;

  logic         vout_r, tout_r, err_r, ovf_r, busy_r;
  logic [127:0] dout_r;

  assign shifted_s = {s.din, shreg_r[127:16]};

  // Assembly next-state: accept, mismatch restart, completion
  always_comb begin
    shreg_s    = shreg_r;
    cnt_s      = cnt_r;
    type_s     = type_r;
    mismatch_s = 1'b0;
    complete_s = 1'b0;
    if (s.vin) begin
      if (cnt_r == 3'd0) begin
        type_s  = s.tin;
        shreg_s = shifted_s;
        cnt_s   = 3'd1;
      end else if (s.tin != type_r) begin
        // Offending word becomes word 0 of a fresh block; old partial is gone.
        mismatch_s = 1'b1;
        type_s     = s.tin;
        shreg_s    = {s.din, 112'd0};
        cnt_s      = 3'd1;
      end else begin
        shreg_s    = shifted_s;
        cnt_s      = cnt_r + 3'd1;
        complete_s = (cnt_r == 3'd7);
      end
    end else begin
      shreg_s = shreg_r;
      cnt_s   = cnt_r;
    end
  end

  // Output register accepts a new block only when empty or being drained
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    if (complete_s) begin
      load_s = !vout_r || s.rdy;
      drop_s = vout_r && !s.rdy;
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= 128'd0;
      cnt_r   <= 3'd0;
      type_r  <= 1'b0;
      vout_r  <= 1'b0;
      tout_r  <= 1'b0;
      dout_r  <= 128'd0;
      err_r   <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      type_r  <= type_s;
      err_r   <= mismatch_s;
      ovf_r   <= drop_s;
      busy_r  <= (cnt_s != 3'd0);
      if (load_s) begin
        dout_r <= shreg_s;
        tout_r <= type_r;
        vout_r <= 1'b1;
      end else if (vout_r && s.rdy) begin
        vout_r <= 1'b0;
      end
    end
  end

  assign s.vout = vout_r;
  assign s.tout = tout_r;
  assign s.dout = dout_r;
  assign s.err  = err_r;
  assign s.ovf  = ovf_r;
  assign s.busy = busy_r;

endmodule

// File: tb/tb_stream_in.sv
// Directed bench for stream_in: vector table plus hand sequences for
// gaps, mismatch, overflow, simultaneous handshake, reset and loopback.
module tb_stream_in;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  stream_in_if bus();
  stream_in dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, vin, tin;
    logic [15:0]  din;
    logic         rdy;
    logic         vout, tout;
    logic [127:0] dout;
    logic         err, ovf, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, vi, ti, input logic [15:0] di, input logic rd,
                              input logic vo, to, input logic [127:0] dd,
                              input logic er, ov, bz);
    vec_t v;
    v.rst = r; v.vin = vi; v.tin = ti; v.din = di; v.rdy = rd;
    v.vout = vo; v.tout = to; v.dout = dd; v.err = er; v.ovf = ov; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic t, input logic [15:0] d);
    bus.vin = 1'b1; bus.tin = t; bus.din = d;
    step();
    bus.vin = 1'b0;
  endtask

  function automatic logic [127:0] mkblk(input logic [15:0] base);
    logic [127:0] b;
    for (int k = 0; k < 8; k++) b[16*k +: 16] = base + 16'(k + 1);
    return b;
  endfunction

  // Reference serializer: LSW first, optional random gaps between words
  task automatic ser_send(input logic [127:0] blk, input logic t, input int gapmax);
    for (int k = 0; k < 8; k++) begin
      word(t, blk[16*k +: 16]);
      if (k < 7) repeat ($urandom_range(0, gapmax)) step();
    end
  endtask

  localparam logic [127:0] D1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] D3 = 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0;

  initial begin
    logic [127:0] a, b, c, r;
    logic         t;
    rst = 1'b1; bus.vin = 1'b0; bus.tin = 1'b0; bus.din = 16'd0; bus.rdy = 1'b0;

    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 128'd0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'(k), 1'b1, 1'b0, 1'b0, 128'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'd8, 1'b1, 1'b1, 1'b1, D1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, D1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, D1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0010 + 16'(k), 1'b1, 1'b0, 1'b1, D1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h00A0, 1'b1, 1'b0, 1'b1, D1, 1'b1, 1'b0, 1'b1));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h00A0 + 16'(k), 1'b1, 1'b0, 1'b1, D1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h00A7, 1'b1, 1'b1, 1'b1, D3, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, D3, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; bus.vin = tbl[i].vin; bus.tin = tbl[i].tin;
      bus.din = tbl[i].din; bus.rdy = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d.vout", i), 128'(bus.vout), 128'(tbl[i].vout));
      chk($sformatf("vec%0d.tout", i), 128'(bus.tout), 128'(tbl[i].tout));
      chk($sformatf("vec%0d.dout", i), bus.dout, tbl[i].dout);
      chk($sformatf("vec%0d.err", i),  128'(bus.err),  128'(tbl[i].err));
      chk($sformatf("vec%0d.ovf", i),  128'(bus.ovf),  128'(tbl[i].ovf));
      chk($sformatf("vec%0d.busy", i), 128'(bus.busy), 128'(tbl[i].busy));
    end
    bus.vin = 1'b0;

    // Gapped data block
    bus.rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      word(1'b0, 16'(k));
      if (k < 8) begin
        chk("gap.busy", 128'(bus.busy), 128'd1);
        chk("gap.vout", 128'(bus.vout), 128'd0);
        repeat ($urandom_range(0, 5)) begin
          step();
          chk("gap.idle_busy", 128'(bus.busy), 128'd1);
          chk("gap.idle_vout", 128'(bus.vout), 128'd0);
        end
      end
    end
    chk("gap.vout_done", 128'(bus.vout), 128'd1);
    chk("gap.dout", bus.dout, D1);
    chk("gap.tout", 128'(bus.tout), 128'd0);
    chk("gap.busy_done", 128'(bus.busy), 128'd0);
    step();
    chk("gap.vout_clear", 128'(bus.vout), 128'd0);

    // Overflow: two blocks with rdy low
    a = mkblk(16'h1000); b = mkblk(16'h2000);
    bus.rdy = 1'b0;
    ser_send(a, 1'b0, 0);
    chk("ovf.a_vout", 128'(bus.vout), 128'd1);
    chk("ovf.a_dout", bus.dout, a);
    for (int k = 0; k < 8; k++) begin
      word(1'b1, b[16*k +: 16]);
      chk("ovf.pulse", 128'(bus.ovf), (k == 7) ? 128'd1 : 128'd0);
      chk("ovf.hold_dout", bus.dout, a);
      chk("ovf.hold_vout", 128'(bus.vout), 128'd1);
    end
    chk("ovf.hold_tout", 128'(bus.tout), 128'd0);
    step();
    chk("ovf.one_cycle", 128'(bus.ovf), 128'd0);
    bus.rdy = 1'b1;
    step();
    chk("ovf.drain_vout", 128'(bus.vout), 128'd0);
    chk("ovf.drain_dout", bus.dout, a);

    // Completion coincides with handshake
    bus.rdy = 1'b0;
    ser_send(a, 1'b0, 0);
    for (int k = 0; k < 7; k++) word(1'b1, b[16*k +: 16]);
    bus.rdy = 1'b1;
    word(1'b1, b[127:112]);
    chk("sim.vout", 128'(bus.vout), 128'd1);
    chk("sim.dout", bus.dout, b);
    chk("sim.tout", 128'(bus.tout), 128'd1);
    chk("sim.ovf", 128'(bus.ovf), 128'd0);
    step();
    chk("sim.vout_clear", 128'(bus.vout), 128'd0);

    // Reset mid-block, with vin asserted in the reset cycle
    for (int k = 0; k < 5; k++) word(1'b1, 16'h3000 + 16'(k));
    chk("rst.busy_before", 128'(bus.busy), 128'd1);
    rst = 1'b1; bus.vin = 1'b1; bus.tin = 1'b0; bus.din = 16'hDEAD;
    step();
    rst = 1'b0; bus.vin = 1'b0;
    chk("rst.busy", 128'(bus.busy), 128'd0);
    chk("rst.vout", 128'(bus.vout), 128'd0);
    chk("rst.err", 128'(bus.err), 128'd0);
    chk("rst.dout", bus.dout, 128'd0);
    c = mkblk(16'h4000);
    for (int k = 0; k < 8; k++) begin
      word(1'b0, c[16*k +: 16]);
      chk("rst.clean_err", 128'(bus.err), 128'd0);
    end
    chk("rst.clean_vout", 128'(bus.vout), 128'd1);
    chk("rst.clean_dout", bus.dout, c);
    step();

    // Loopback through the reference serializer
    for (int n = 0; n < 4; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      t = 1'($urandom_range(0, 1));
      ser_send(r, t, 2);
      chk($sformatf("loop%0d.vout", n), 128'(bus.vout), 128'd1);
      chk($sformatf("loop%0d.dout", n), bus.dout, r);
      chk($sformatf("loop%0d.tout", n), 128'(bus.tout), 128'(t));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_in.md
STREAM_IN -- requirements
Module: stream_in

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset: synchronous, active-high
- vin  input  1  input word valid
- tin  input  1  input word type (1 = key, 0 = data), sampled with vin
- din  input  16  input word
- rdy  input  1  downstream accepts the current output block
- vout  output  1  output block valid
- tout  output  1  type of the output block
- dout  output  128  assembled output block
- err  output  1  one-cycle pulse: type mismatch inside a block
- ovf  output  1  one-cycle pulse: completed block dropped
- busy  output  1  partial block in progress (word count != 0)

REQ-002 The block SHALL have no parameters; the block is fixed at 8 words of 16 bits.

Function
REQ-003 The block SHALL deserialize eight 16-bit words into one 128-bit block: least-significant word first, word k landing in dout[16k+15:16k].
- This is the inverse of the team's 128-to-16 stream serializer.
REQ-004 The assembly path SHALL hold:
- a 128-bit shift register, shifted on each accepted word as {din, shreg[127:16]};
- a 3-bit word counter, 0..7;
- a 1-bit block type register.
REQ-005 A word SHALL be accepted on every cycle with vin=1; no input backpressure exists.
REQ-006 When an accepted word arrives with count=0, its tin SHALL be latched as the block type.
REQ-007 When an accepted word arrives with count!=0 and tin differs from the latched type:
- the partial block SHALL be discarded;
- err SHALL pulse the next cycle;
- the word SHALL start a new block (type=tin, count=1).
REQ-008 Accepting the 8th word (count=7) SHALL complete the block and wrap count to 0.
REQ-009 The output register (dout, tout, vout) SHALL load the completed block ({din, shreg[127:16]}) when vout=0 or (vout=1 and rdy=1) in the same cycle.
- vout then asserts the cycle after the 8th word: latency 1 cycle.
REQ-010 When a block completes while vout=1 and rdy=0, the block SHALL be dropped, ovf SHALL pulse the next cycle, and the output register SHALL be unchanged.
REQ-011 vout, dout and tout SHALL hold stable while vout=1 and rdy=0.
REQ-012 A rdy=1 cycle with vout=1 and no block completing SHALL clear vout the next cycle; dout and tout hold their last value.
REQ-013 rdy SHALL be ignored while vout=0.
REQ-014 Simultaneous completion and handshake (vout=1, rdy=1, 8th word) SHALL load the new block with vout remaining 1, with no ovf.
REQ-015 vin=0 cycles SHALL leave the assembly state unchanged; gaps between words of a block are allowed and unbounded.
REQ-016 busy SHALL equal (count != 0), registered.
REQ-017 err and ovf SHALL never be asserted for more than one cycle per event.
REQ-018 err SHALL take precedence: a mismatching word never completes a block, even at count=7.

Reset
REQ-019 When rst=1, the following SHALL be forced:
- count=0, type=0, shreg=0;
- vout=0, tout=0, dout=0;
- err=0, ovf=0, busy=0.
REQ-020 rst SHALL override vin and rdy in the same cycle; a partial block present at reset SHALL be discarded with no err.
REQ-021 The first word accepted after rst deasserts SHALL be treated as word 0 of a new block.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Back-to-back words 0x0001..0x0008, tin=1, rdy=1 -> one cycle after the 8th word: vout=1, tout=1, dout=0x0008_0007_0006_0005_0004_0003_0002_0001; vout=0 the following cycle.
- 8 words with random vin gaps of 0-5 cycles, tin=0 -> a single vout, identical dout; busy=1 from word 1 until the 8th word.
- Words 1-3 with tin=0, then word with tin=1 -> err pulses exactly 1 cycle; that word starts a new key block; 7 further tin=1 words -> vout with tout=1, and the offending word sits in dout[15:0].
- rdy=0, two complete blocks A then B -> vout holds A; ovf pulses once after B's 8th word; rdy=1 -> A consumed, vout=0.
- vout=1 with block A, rdy=1 in the same cycle as block B's 8th word -> next cycle vout=1, dout=B, ovf=0.
- rst asserted after 5 words -> busy=0, vout=0; the next 8 words form a clean block with no err.
- End-to-end loopback: serializer output feeding this block -> every 128-bit block and type reproduced bit-exact.
